ahb_lite_sram_slave: RTL and testbench

- AHB-Lite responder (slave) that terminates transfers issued by the team's AHB initiator.
- Backs a word-addressed register-array memory.
- Supports byte, halfword and word accesses, a configurable number of wait states, and the two-cycle ERROR response.
- Sits on the slave side of the decoder/mux; HSEL comes from the decoder and HREADY is the muxed bus ready.

---
 rtl/ahb_lite_sram_slave.sv | 191 +++++++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave
// AHB-Lite responder backed by a word-addressed memory of MEM_DEPTH words.
// It supports byte, halfword and word writes, WAIT_STATES stall cycles on
// every OKAY data phase, and the two-cycle ERROR response. Read data is
// registered and loaded on the edge that enters the final data-phase cycle.
//
// Ports:
//   HCLK       clock, rising edge
//   HRESET     synchronous active-high reset
//   HSEL       slave select from the address decoder
//   HADDR      byte address
//   HTRANS     transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HWRITE     1 = write
//   HSIZE      000 byte, 001 halfword, 010 word
//   HBURST     not used; burst beats are handled as independent transfers
//   HWDATA     write data, valid in the data phase
//   HREADY     muxed bus ready
//   HREADYOUT  this slave's ready
//   HRESP      0 = OKAY, 1 = ERROR
//   HRDATA     read data
module ahb_lite_sram_slave #(
  parameter int BUS_WIDTH   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [BUS_WIDTH-1:0]  HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int         IDX_W     = $clog2(MEM_DEPTH);
  localparam int         LANES     = DATA_WIDTH / 8;
  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              wait_cnt_reg, wait_cnt_next;
  logic [IDX_W-1:0]        addr_idx_reg;
  logic [1:0]              lane_reg;
  logic [1:0]              size_reg;
  logic                    write_reg;
  logic [DATA_WIDTH-1:0]   hrdata_reg;

  logic                    accept;
  logic                    capture;
  logic                    addr_err, size_err, align_err, req_err;
  logic [LANES-1:0]        be;
  logic [LANES-1:0]        commit_we;
  logic [IDX_W-1:0]        load_idx;
  logic                    load_en;
  logic                    hit;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    unused_bits;

  assign unused_bits = ^{HBURST, HTRANS[0]};

  assign accept = HSEL & HREADY & HTRANS[1];

  // With a power-of-two depth, "word index >= MEM_DEPTH" is simply any set
  // bit above the index field.
  assign addr_err  = |HADDR[BUS_WIDTH-1:IDX_W+2];
  assign size_err  = HSIZE[2] | (HSIZE[1:0] == 2'b11);
  assign align_err = ((HSIZE == 3'b001) && HADDR[0]) ||
                     ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
  assign req_err   = addr_err | size_err | align_err;

  // Next-state and bus outputs.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    capture       = 1'b0;
    HREADYOUT     = 1'b1;
    HRESP         = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        HRESP = (state_reg == ST_ERR2);
        if (accept) begin
          capture = 1'b1;
          if (req_err) begin
            state_next = ST_ERR1;
          end else if (HAS_WAIT) begin
            state_next    = ST_WAIT;
            wait_cnt_next = WAIT_INIT;
          end else begin
            state_next = ST_DATA;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt_reg == '0) begin
          state_next = ST_DATA;
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end
      ST_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        state_next = ST_ERR2;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Byte enables of the pending data phase (little-endian lanes).
  always_comb begin
    case (size_reg)
      2'b00:   be = 4'b0001 << lane_reg;
      2'b01:   be = lane_reg[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // A write commits only on the edge leaving ST_DATA, and never while reset
  // is asserted so that a reset aborts the transfer cleanly.
  assign commit_we = ((state_reg == ST_DATA) && write_reg && !HRESET) ? be : '0;

  // The read word is fetched either for a transfer being accepted right now
  // (no wait states) or for the pending one on its last wait cycle.
  assign load_idx = (state_reg == ST_WAIT) ? addr_idx_reg : HADDR[IDX_W+1:2];
  assign load_en  = (capture && !req_err && !HAS_WAIT && !HWRITE) ||
                    ((state_reg == ST_WAIT) && (wait_cnt_reg == '0) && !write_reg);
  assign hit      = (addr_idx_reg == load_idx);

  // One byte-wide memory per lane; a committing write to the same word is
  // forwarded lane by lane into the read data being loaded on that edge.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem_lane [MEM_DEPTH];

      always_ff @(posedge HCLK) begin
        if (commit_we[gi]) begin
          mem_lane[addr_idx_reg] <= HWDATA[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = (commit_we[gi] && hit) ? HWDATA[8*gi +: 8]
                                                         : mem_lane[load_idx];
    end
  endgenerate

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
      addr_idx_reg <= '0;
      lane_reg     <= '0;
      size_reg     <= '0;
      write_reg    <= 1'b0;
      hrdata_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (capture) begin
        addr_idx_reg <= HADDR[IDX_W+1:2];
        lane_reg     <= HADDR[1:0];
        size_reg     <= HSIZE[1:0];
        write_reg    <= HWRITE;
      end
      if (load_en) begin
        hrdata_reg <= rd_word;
      end
    end
  end

  assign HRDATA = hrdata_reg;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: one instance with no wait states (dut0) and
// one with three (dut3) share the bus signals; HSEL picks the target and
// HREADY is the selected slave's HREADYOUT. A byte-addressed model holds
// the expected memory contents and the last read word of each instance.
module tb_ahb_lite_sram_slave;

  localparam int DEPTH = 256;

  logic        HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HRESET;
  logic        hsel0, hsel1;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        ro0, ro1, resp0, resp1;
  logic [31:0] rd0, rd1;
  bit          dut_sel;
  bit          force_low;
  logic        hready;

  assign hready = force_low ? 1'b0 : (dut_sel ? ro1 : ro0);

  ahb_lite_sram_slave #(.BUS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(hready),
    .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rd0)
  );

  ahb_lite_sram_slave #(.BUS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(hready),
    .HREADYOUT(ro1), .HRESP(resp1), .HRDATA(rd1)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem_m [2][1024];
  logic [31:0] last_rd [2];

  typedef struct {
    bit          sel;
    logic [31:0] addr;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          exp_err;
    int          exp_waits;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] addr, input logic [2:0] size);
    return ((addr >> 2) >= 32'(DEPTH)) || (size > 3'd2) ||
           (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_word(input bit sel, input logic [31:0] addr);
    int a;
    a = int'(addr & 32'h3FC);
    return {mem_m[sel][a+3], mem_m[sel][a+2], mem_m[sel][a+1], mem_m[sel][a]};
  endfunction

  // Each byte addressed by a legal write takes its own lane of HWDATA.
  task automatic model_commit(input bit sel, input logic [31:0] addr, input bit wr,
                              input logic [2:0] size, input logic [31:0] wdata);
    int n;
    int ba;
    if (is_err(addr, size)) return;
    if (wr) begin
      n = 1 << size;
      for (int b = 0; b < n; b++) begin
        ba = int'(addr) + b;
        mem_m[sel][ba] = wdata[8*(ba % 4) +: 8];
      end
    end else begin
      last_rd[sel] = model_word(sel, addr);
    end
  endtask

  task automatic select(input bit sel);
    dut_sel = sel;
    hsel0   = !sel;
    hsel1   = sel;
  endtask

  task automatic do_xfer(input bit sel, input logic [31:0] addr, input bit wr, input logic [2:0] size,
                         input logic [31:0] wdata, input bit exp_err, input int exp_waits,
                         input bit chk_rd, input logic [31:0] exp_rd, input string tag);
    int   waits;
    bit   done;
    bit   low_resp_bad;
    logic fin_resp;
    logic [31:0] fin_rd;
    @(negedge HCLK);
    select(sel);
    HADDR  = addr;
    HTRANS = 2'b10;
    HWRITE = wr;
    HSIZE  = size;
    @(posedge HCLK);
    #1;
    HTRANS = 2'b00;
    HWDATA = wdata;
    waits = 0;
    done = 0;
    low_resp_bad = 0;
    fin_resp = 1'b0;
    fin_rd = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge HCLK);
      if ((sel ? ro1 : ro0) === 1'b1) begin
        done = 1;
        fin_resp = sel ? resp1 : resp0;
        fin_rd   = sel ? rd1 : rd0;
      end else begin
        waits++;
        if ((sel ? resp1 : resp0) !== exp_err) low_resp_bad = 1;
      end
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_waits"}, 32'(waits), 32'(exp_waits));
    chk({tag, "_lowresp"}, {31'd0, low_resp_bad}, 32'd0);
    chk({tag, "_resp"}, {31'd0, fin_resp}, {31'd0, exp_err});
    if (chk_rd) chk({tag, "_rdata"}, fin_rd, exp_rd);
    $display("xfer %s dut=%0d addr=0x%08h %s size=%0d wdata=0x%08h resp=%0d rdata=0x%08h waits=%0d",
             tag, sel ? 3 : 0, addr, wr ? "W" : "R", size, wdata, fin_resp, fin_rd, waits);
    @(posedge HCLK);
  endtask

  task automatic model_xfer(input bit sel, input logic [31:0] addr, input bit wr,
                            input logic [2:0] size, input logic [31:0] wdata, input string tag);
    bit err;
    logic [31:0] exp_rd;
    err = is_err(addr, size);
    exp_rd = (!wr && !err) ? model_word(sel, addr) : last_rd[sel];
    do_xfer(sel, addr, wr, size, wdata, err, err ? 1 : (sel ? 3 : 0), 1'b1, exp_rd, tag);
    model_commit(sel, addr, wr, size, wdata);
  endtask

  // Write immediately followed by a pipelined word read on dut0.
  task automatic b2b(input logic [31:0] waddr, input logic [2:0] wsize, input logic [31:0] wdata,
                     input logic [31:0] raddr, input logic [31:0] exp, input string tag);
    @(negedge HCLK);
    select(1'b0);
    HADDR  = waddr;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HSIZE  = wsize;
    @(negedge HCLK);
    chk({tag, "_wready"}, {31'd0, ro0}, 32'd1);
    HWDATA = wdata;
    HADDR  = raddr;
    HWRITE = 1'b0;
    HSIZE  = 3'b010;
    @(negedge HCLK);
    HTRANS = 2'b00;
    chk({tag, "_rready"}, {31'd0, ro0}, 32'd1);
    chk({tag, "_rresp"}, {31'd0, resp0}, 32'd0);
    chk({tag, "_rdata"}, rd0, exp);
    $display("xfer %s dut=0 W 0x%08h=0x%08h then R 0x%08h rdata=0x%08h", tag, waddr, wdata, raddr, rd0);
    @(posedge HCLK);
    model_commit(1'b0, waddr, 1'b1, wsize, wdata);
    model_commit(1'b0, raddr, 1'b0, 3'd2, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int low;
    bit got;
    logic [31:0] old;
    logic [31:0] a;
    logic [2:0]  sz;
    bit          w;
    bit          s;

    tbl[0]  = '{1'b0, 32'h10,  1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,  1'b0, 3'd2, 32'h0,        1'b0, 0, 1'b1, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 32'h20,  1'b1, 3'd2, 32'h11223344, 1'b0, 0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h21,  1'b1, 3'd0, 32'h0000AA00, 1'b0, 0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h22,  1'b1, 3'd1, 32'hBBBB0000, 1'b0, 0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 32'h20,  1'b0, 3'd2, 32'h0,        1'b0, 0, 1'b1, 32'hBBBBAA44};
    tbl[6]  = '{1'b0, 32'h00,  1'b1, 3'd2, 32'h55667788, 1'b0, 0, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h400, 1'b0, 3'd2, 32'h0,        1'b1, 1, 1'b1, 32'hBBBBAA44};
    tbl[8]  = '{1'b0, 32'h02,  1'b0, 3'd2, 32'h0,        1'b1, 1, 1'b1, 32'hBBBBAA44};
    tbl[9]  = '{1'b0, 32'h01,  1'b1, 3'd1, 32'hFFFFFFFF, 1'b1, 1, 1'b1, 32'hBBBBAA44};
    tbl[10] = '{1'b0, 32'h00,  1'b1, 3'd3, 32'hFFFFFFFF, 1'b1, 1, 1'b1, 32'hBBBBAA44};
    tbl[11] = '{1'b0, 32'h00,  1'b0, 3'd2, 32'h0,        1'b0, 0, 1'b1, 32'h55667788};
    tbl[12] = '{1'b1, 32'h08,  1'b1, 3'd2, 32'h0BADC0DE, 1'b0, 3, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 32'h08,  1'b0, 3'd2, 32'h0,        1'b0, 3, 1'b1, 32'h0BADC0DE};
    tbl[14] = '{1'b1, 32'h3FC, 1'b1, 3'd2, 32'hA5A55A5A, 1'b0, 3, 1'b0, 32'h0};
    tbl[15] = '{1'b1, 32'h3FC, 1'b0, 3'd2, 32'h0,        1'b0, 3, 1'b1, 32'hA5A55A5A};
    tbl[16] = '{1'b1, 32'h400, 1'b1, 3'd2, 32'h12345678, 1'b1, 1, 1'b1, 32'hA5A55A5A};
    tbl[17] = '{1'b0, 32'h23,  1'b0, 3'd0, 32'h0,        1'b0, 0, 1'b1, 32'hBBBBAA44};
    tbl[18] = '{1'b0, 32'h22,  1'b0, 3'd1, 32'h0,        1'b0, 0, 1'b1, 32'hBBBBAA44};

    HRESET = 1'b1;
    hsel0 = 1'b0; hsel1 = 1'b0; dut_sel = 1'b0; force_low = 1'b0;
    HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2; HBURST = 3'd0; HWDATA = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;

    // Reset state.
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_ready0", {31'd0, ro0}, 32'd1);
    chk("rst_resp0", {31'd0, resp0}, 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_ready3", {31'd0, ro1}, 32'd1);
    chk("rst_resp3", {31'd0, resp1}, 32'd0);
    chk("rst_rdata3", rd1, 32'd0);
    HRESET = 1'b0;

    // Give the first 64 words of both memories known contents.
    for (int wi = 0; wi < 64; wi++) begin
      model_xfer(1'b0, 32'(wi * 4), 1'b1, 3'd2, $urandom, "init");
      model_xfer(1'b1, 32'(wi * 4), 1'b1, 3'd2, $urandom, "init");
    end

    // Directed vectors.
    for (int i = 0; i < 19; i++) begin
      do_xfer(tbl[i].sel, tbl[i].addr, tbl[i].wr, tbl[i].size, tbl[i].wdata, tbl[i].exp_err,
              tbl[i].exp_waits, tbl[i].chk_rd, tbl[i].exp_rd, $sformatf("vec%0d", i));
      model_commit(tbl[i].sel, tbl[i].addr, tbl[i].wr, tbl[i].size, tbl[i].wdata);
    end

    // Write-to-read forwarding, whole word and a single lane.
    b2b(32'h40, 3'd2, 32'hCAFEF00D, 32'h40, 32'hCAFEF00D, "b2b_word");
    b2b(32'h41, 3'd0, 32'h00005500, 32'h40, 32'hCAFE550D, "b2b_byte");

    // dut3: second request held on the bus through the first one's waits.
    @(negedge HCLK);
    select(1'b1);
    HADDR = 32'h08; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2;
    @(posedge HCLK);
    #1;
    HADDR = 32'h0C;
    for (int t = 0; t < 2; t++) begin
      low = 0;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge HCLK);
        if (ro1 === 1'b1) got = 1;
        else low++;
      end
      chk($sformatf("ws_low%0d", t), 32'(low), 32'd3);
      chk($sformatf("ws_rdata%0d", t), rd1, model_word(1'b1, t == 0 ? 32'h08 : 32'h0C));
      $display("xfer ws_pipe%0d dut=3 R rdata=0x%08h low=%0d", t, rd1, low);
      @(posedge HCLK);
      #1;
      HTRANS = 2'b00;
    end
    last_rd[1] = model_word(1'b1, 32'h0C);

    // Reset during the wait states of a write.
    old = model_word(1'b1, 32'h30);
    @(negedge HCLK);
    select(1'b1);
    HADDR = 32'h30; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK);
    #1;
    HTRANS = 2'b00;
    HWDATA = 32'h12345678;
    @(negedge HCLK);
    chk("rstw_low", {31'd0, ro1}, 32'd0);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("rstw_ready", {31'd0, ro1}, 32'd1);
    chk("rstw_resp", {31'd0, resp1}, 32'd0);
    chk("rstw_rdata3", rd1, 32'd0);
    chk("rstw_rdata0", rd0, 32'd0);
    $display("xfer rst_wait dut=3 W 0x00000030 aborted by reset");
    HRESET = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    model_xfer(1'b1, 32'h30, 1'b0, 3'd2, 32'd0, "rstw_read");
    chk("rstw_old", last_rd[1], old);

    // IDLE and BUSY with HSEL high: zero-wait OKAY, read data held.
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      select(1'b0);
      HTRANS = (i % 2) ? 2'b01 : 2'b00;
      HADDR  = $urandom;
      HWRITE = 1'($urandom);
      HSIZE  = 3'($urandom_range(0, 2));
      @(negedge HCLK);
      chk($sformatf("idle%0d_ready", i), {31'd0, ro0}, 32'd1);
      chk($sformatf("idle%0d_resp", i), {31'd0, resp0}, 32'd0);
      chk($sformatf("idle%0d_rdata", i), rd0, last_rd[0]);
      $display("xfer idle%0d dut=0 htrans=%0d", i, HTRANS);
    end
    HTRANS = 2'b00;

    // HREADY low: a NONSEQ on the bus must not be taken.
    @(negedge HCLK);
    select(1'b0);
    force_low = 1'b1;
    HADDR = 32'h00; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK);
    #1;
    HTRANS = 2'b00;
    HWDATA = 32'hFFFFFFFF;
    force_low = 1'b0;
    @(negedge HCLK);
    chk("hrdy_low_ready", {31'd0, ro0}, 32'd1);
    $display("xfer hready_low dut=0 W 0x00000000 ignored");
    model_xfer(1'b0, 32'h00, 1'b0, 3'd2, 32'd0, "hrdy_low_read");

    // Randomized transfers against the model.
    for (int i = 0; i < 200; i++) begin
      s  = 1'($urandom);
      w  = 1'($urandom);
      a  = ($urandom_range(0, 9) == 0) ? 32'h400 + 32'($urandom_range(0, 4095))
                                       : 32'($urandom_range(0, 255));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      model_xfer(s, a, w, sz, $urandom, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
